dual_port_memory_arbiter: RTL and testbench

Two-requester arbiter that shares a single port of the latency-parameterised dual-port memory. It accepts read/write requests over valid/ready handshakes and issues at most one memory command per cycle. Read data is routed back to the issuing requester after the memory's fixed read latency. Reads to an address with an in-flight write are held until that write has landed. It sits between client logic and one memory port (A or B), in that port's clock domain.

---
 rtl/dual_port_memory_arbiter.sv | 182 ++++++++++++++++++
 tb/tb_dual_port_memory_arbiter.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/dual_port_memory_arbiter.sv
// dual_port_memory_arbiter: shares one memory port between two requesters.
// Issues at most one command per cycle, holds reads behind in-flight writes
// to the same address, and routes read data back after READ_LATENCY.
// Optional macro DUAL_PORT_MEMORY_ARBITER_RR_EN selects round-robin
// arbitration; without it requester 0 has fixed priority.
module dual_port_memory_arbiter #(
  parameter int WIDTH         = 8,
  parameter int ADDR_WIDTH    = 3,
  parameter int READ_LATENCY  = 5,
  parameter int WRITE_LATENCY = 4
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_req_valid_0,
  input  logic                  i_req_valid_1,
  output logic                  o_req_ready_0,
  output logic                  o_req_ready_1,
  input  logic                  i_req_we_0,
  input  logic                  i_req_we_1,
  input  logic [ADDR_WIDTH-1:0] i_req_addr_0,
  input  logic [ADDR_WIDTH-1:0] i_req_addr_1,
  input  logic [WIDTH-1:0]      i_req_din_0,
  input  logic [WIDTH-1:0]      i_req_din_1,
  output logic                  o_rsp_valid_0,
  output logic                  o_rsp_valid_1,
  output logic [WIDTH-1:0]      o_rsp_dout_0,
  output logic [WIDTH-1:0]      o_rsp_dout_1,
  output logic                  o_mem_en,
  output logic                  o_mem_we,
  output logic [ADDR_WIDTH-1:0] o_mem_addr,
  output logic [WIDTH-1:0]      o_mem_din,
  input  logic [WIDTH-1:0]      i_mem_dout
);

  localparam int HZ_N  = WRITE_LATENCY + 1;
  localparam int TAG_N = READ_LATENCY + 1;

  logic [HZ_N-1:0]       hz_vld_q, hz_vld_d;
  logic [ADDR_WIDTH-1:0] hz_addr_q [HZ_N];
  logic [ADDR_WIDTH-1:0] hz_addr_d [HZ_N];
  logic [TAG_N-1:0]      tag_vld_q, tag_vld_d;
  logic [TAG_N-1:0]      tag_id_q, tag_id_d;

  logic                  mem_en_q, mem_en_d;
  logic                  mem_we_q, mem_we_d;
  logic                  mem_id_q, mem_id_d;
  logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic [WIDTH-1:0]      mem_din_q, mem_din_d;

  logic                  rsp_valid_0_q, rsp_valid_0_d;
  logic                  rsp_valid_1_q, rsp_valid_1_d;
  logic [WIDTH-1:0]      rsp_dout_0_q, rsp_dout_0_d;
  logic [WIDTH-1:0]      rsp_dout_1_q, rsp_dout_1_d;

  logic                  haz_0, haz_1, elig_0, elig_1, gnt_0, gnt_1, acc;
  logic                  sel_we;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [WIDTH-1:0]      sel_din;

  // A read is eligible only when no in-flight write targets its address.
  always_comb begin
    haz_0 = 1'b0;
    haz_1 = 1'b0;
    for (int i = 0; i < HZ_N; i++) begin
      if (hz_vld_q[i] && (hz_addr_q[i] == i_req_addr_0)) haz_0 = 1'b1;
      if (hz_vld_q[i] && (hz_addr_q[i] == i_req_addr_1)) haz_1 = 1'b1;
    end
    elig_0 = i_req_valid_0 && !i_rst && (i_req_we_0 || !haz_0);
    elig_1 = i_req_valid_1 && !i_rst && (i_req_we_1 || !haz_1);
  end

`ifdef DUAL_PORT_MEMORY_ARBITER_RR_EN
  logic last_q, last_d;

  // On a tie the requester that was not granted last wins.
  always_comb begin
    gnt_0  = 1'b0;
    gnt_1  = 1'b0;
    last_d = last_q;
    if (elig_0 && elig_1) begin
      gnt_0 = last_q;
      gnt_1 = !last_q;
    end else begin
      gnt_0 = elig_0;
      gnt_1 = elig_1;
    end
    if (gnt_0) last_d = 1'b0;
    else if (gnt_1) last_d = 1'b1;
  end

  // Last-granted register; reset to 1 so requester 0 wins the first tie.
  always_ff @(posedge i_clk) begin
    if (i_rst) last_q <= 1'b1;
    else       last_q <= last_d;
  end
`else
  // Fixed priority: requester 1 only when requester 0 cannot go.
  always_comb begin
    gnt_0 = elig_0;
    gnt_1 = elig_1 && !elig_0;
  end
`endif

  // Command mux, hazard/tag shift pipelines and response capture.
  always_comb begin
    acc      = gnt_0 || gnt_1;
    sel_we   = gnt_1 ? i_req_we_1   : i_req_we_0;
    sel_addr = gnt_1 ? i_req_addr_1 : i_req_addr_0;
    sel_din  = gnt_1 ? i_req_din_1  : i_req_din_0;

    mem_en_d   = acc;
    mem_we_d   = acc && sel_we;
    mem_id_d   = gnt_1;
    mem_addr_d = acc ? sel_addr : mem_addr_q;
    mem_din_d  = acc ? sel_din  : mem_din_q;

    hz_vld_d[0]  = acc && sel_we;
    hz_addr_d[0] = sel_addr;
    for (int i = 1; i < HZ_N; i++) begin
      hz_vld_d[i]  = hz_vld_q[i-1];
      hz_addr_d[i] = hz_addr_q[i-1];
    end

    // Tags start when the memory samples the read command.
    tag_vld_d[0] = mem_en_q && !mem_we_q;
    tag_id_d[0]  = mem_id_q;
    for (int i = 1; i < TAG_N; i++) begin
      tag_vld_d[i] = tag_vld_q[i-1];
      tag_id_d[i]  = tag_id_q[i-1];
    end

    rsp_valid_0_d = tag_vld_q[TAG_N-1] && !tag_id_q[TAG_N-1];
    rsp_valid_1_d = tag_vld_q[TAG_N-1] &&  tag_id_q[TAG_N-1];
    rsp_dout_0_d  = rsp_valid_0_d ? i_mem_dout : rsp_dout_0_q;
    rsp_dout_1_d  = rsp_valid_1_d ? i_mem_dout : rsp_dout_1_q;
  end

  // State registers; reset clears outputs and both pipelines.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      hz_vld_q      <= '0;
      tag_vld_q     <= '0;
      tag_id_q      <= '0;
      mem_en_q      <= 1'b0;
      mem_we_q      <= 1'b0;
      mem_id_q      <= 1'b0;
      mem_addr_q    <= '0;
      mem_din_q     <= '0;
      rsp_valid_0_q <= 1'b0;
      rsp_valid_1_q <= 1'b0;
      rsp_dout_0_q  <= '0;
      rsp_dout_1_q  <= '0;
      for (int i = 0; i < HZ_N; i++) hz_addr_q[i] <= '0;
    end else begin
      hz_vld_q      <= hz_vld_d;
      tag_vld_q     <= tag_vld_d;
      tag_id_q      <= tag_id_d;
      mem_en_q      <= mem_en_d;
      mem_we_q      <= mem_we_d;
      mem_id_q      <= mem_id_d;
      mem_addr_q    <= mem_addr_d;
      mem_din_q     <= mem_din_d;
      rsp_valid_0_q <= rsp_valid_0_d;
      rsp_valid_1_q <= rsp_valid_1_d;
      rsp_dout_0_q  <= rsp_dout_0_d;
      rsp_dout_1_q  <= rsp_dout_1_d;
      for (int i = 0; i < HZ_N; i++) hz_addr_q[i] <= hz_addr_d[i];
    end
  end

  assign o_req_ready_0 = gnt_0;
  assign o_req_ready_1 = gnt_1;
  assign o_mem_en      = mem_en_q;
  assign o_mem_we      = mem_we_q;
  assign o_mem_addr    = mem_addr_q;
  assign o_mem_din     = mem_din_q;
  assign o_rsp_valid_0 = rsp_valid_0_q;
  assign o_rsp_valid_1 = rsp_valid_1_q;
  assign o_rsp_dout_0  = rsp_dout_0_q;
  assign o_rsp_dout_1  = rsp_dout_1_q;

endmodule

// File: tb/tb_dual_port_memory_arbiter.sv
// Testbench for dual_port_memory_arbiter: behavioural memory with
// READ_LATENCY/WRITE_LATENCY, a cycle table of requests with expected
// grants, and hand-written reset / write-then-read sequences.
module tb_dual_port_memory_arbiter;

  localparam int RL = 5;
  localparam int WL = 4;
`ifdef DUAL_PORT_MEMORY_ARBITER_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       i_rst = 1'b1;
  logic       v0 = 1'b0, v1 = 1'b0, we0 = 1'b0, we1 = 1'b0;
  logic [2:0] a0 = '0, a1 = '0;
  logic [7:0] d0 = '0, d1 = '0;
  logic       r0, r1, rv0, rv1, mem_en, mem_we;
  logic [7:0] rd0, rd1, mem_din, mem_dout;
  logic [2:0] mem_addr;

  dual_port_memory_arbiter #(
    .WIDTH(8), .ADDR_WIDTH(3), .READ_LATENCY(RL), .WRITE_LATENCY(WL)
  ) dut (
    .i_clk(clk), .i_rst(i_rst),
    .i_req_valid_0(v0), .i_req_valid_1(v1),
    .o_req_ready_0(r0), .o_req_ready_1(r1),
    .i_req_we_0(we0), .i_req_we_1(we1),
    .i_req_addr_0(a0), .i_req_addr_1(a1),
    .i_req_din_0(d0), .i_req_din_1(d1),
    .o_rsp_valid_0(rv0), .o_rsp_valid_1(rv1),
    .o_rsp_dout_0(rd0), .o_rsp_dout_1(rd1),
    .o_mem_en(mem_en), .o_mem_we(mem_we),
    .o_mem_addr(mem_addr), .o_mem_din(mem_din),
    .i_mem_dout(mem_dout)
  );

  always #5 clk = ~clk;

  // Memory model: unwritten location a reads as 0x30+a.
  logic [7:0] mem [8];
  bit   [7:0] written;
  logic [7:0] rd_pipe [RL];
  logic       wr_v [WL];
  logic [2:0] wr_a [WL];
  logic [7:0] wr_d [WL];

  always @(posedge clk) begin
    rd_pipe[0] <= written[mem_addr] ? mem[mem_addr] : {5'b00110, mem_addr};
    for (int k = 1; k < RL; k++) rd_pipe[k] <= rd_pipe[k-1];
    mem_dout <= rd_pipe[RL-1];
    wr_v[0] <= mem_en && mem_we;
    wr_a[0] <= mem_addr;
    wr_d[0] <= mem_din;
    for (int k = 1; k < WL; k++) begin
      wr_v[k] <= wr_v[k-1];
      wr_a[k] <= wr_a[k-1];
      wr_d[k] <= wr_d[k-1];
    end
    if (wr_v[WL-1]) begin
      mem[wr_a[WL-1]]     <= wr_d[WL-1];
      written[wr_a[WL-1]] <= 1'b1;
    end
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         c;
    logic       id;
    logic [7:0] data;
  } rsp_t;
  rsp_t obs_q[$];
  rsp_t exp_q[$];

  // Response monitor, sampled on the falling edge.
  always @(negedge clk) begin
    if (rv0) obs_q.push_back('{cyc, 1'b0, rd0});
    if (rv1) obs_q.push_back('{cyc, 1'b1, rd1});
  end

  int tests_run = 0;
  int tests_failed = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    tests_run++;
    if (act !== req) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic compare_rsp(input string name);
    int n;
    check({name, "_count"}, obs_q.size(), exp_q.size());
    n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      check({name, "_cycle"}, obs_q[i].c, exp_q[i].c);
      check({name, "_id"}, {31'd0, obs_q[i].id}, {31'd0, exp_q[i].id});
      check({name, "_data"}, {24'd0, obs_q[i].data}, {24'd0, exp_q[i].data});
    end
    obs_q.delete();
    exp_q.delete();
  endtask

  task automatic idle();
    v0 = 1'b0; v1 = 1'b0; we0 = 1'b0; we1 = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    idle();
    i_rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    i_rst = 1'b0;
    #1;
    obs_q.delete();
    exp_q.delete();
  endtask

  typedef struct {
    logic       v0, we0;
    logic [2:0] a0;
    logic [7:0] d0;
    logic       v1, we1;
    logic [2:0] a1;
    logic [7:0] d1;
    logic       r0, r1;
    logic [7:0] x0, x1;
  } vec_t;

  function automatic vec_t mk(logic pv0, logic pwe0, logic [2:0] pa0, logic [7:0] pd0,
                              logic pv1, logic pwe1, logic [2:0] pa1, logic [7:0] pd1,
                              logic pr0, logic pr1, logic [7:0] px0, logic [7:0] px1);
    vec_t t;
    t.v0 = pv0; t.we0 = pwe0; t.a0 = pa0; t.d0 = pd0;
    t.v1 = pv1; t.we1 = pwe1; t.a1 = pa1; t.d1 = pd1;
    t.r0 = pr0; t.r1 = pr1; t.x0 = px0; t.x1 = px1;
    return t;
  endfunction

  vec_t vt [21];

  initial begin
    int e0;
    // Cycle table run right after reset (last = 1).
    for (int i = 0; i < 4; i++)
      vt[i] = mk(1, 0, 3'd4, 8'h00, 1, 0, 3'd5, 8'h00,
                 (i % 2 == 0) ? 1'b1 : !RR, (i % 2 == 0) ? 1'b0 : RR, 8'h34, 8'h35);
    vt[4]  = mk(0, 0, 3'd0, 8'h00, 1, 0, 3'd5, 8'h00, 0, 1, 8'h00, 8'h35);
    vt[5]  = mk(1, 1, 3'd2, 8'h09, 1, 0, 3'd2, 8'h00, 1, 0, 8'h00, 8'h00);
    vt[6]  = mk(1, 0, 3'd3, 8'h00, 1, 0, 3'd2, 8'h00, 1, 0, 8'h33, 8'h00);
    for (int i = 7; i < 11; i++)
      vt[i] = mk(0, 0, 3'd0, 8'h00, 1, 0, 3'd2, 8'h00, 0, 0, 8'h00, 8'h00);
    vt[11] = mk(0, 0, 3'd0, 8'h00, 1, 0, 3'd2, 8'h00, 0, 1, 8'h00, 8'h09);
    vt[12] = mk(1, 0, 3'd6, 8'h00, 1, 1, 3'd6, 8'h77, 1, 0, 8'h36, 8'h00);
    vt[13] = mk(0, 0, 3'd0, 8'h00, 1, 1, 3'd6, 8'h77, 0, 1, 8'h00, 8'h00);
    vt[14] = mk(1, 0, 3'd6, 8'h00, 1, 1, 3'd6, 8'h78, 0, 1, 8'h00, 8'h00);
    for (int i = 15; i < 20; i++)
      vt[i] = mk(1, 0, 3'd6, 8'h00, 0, 0, 3'd0, 8'h00, 0, 0, 8'h00, 8'h00);
    vt[20] = mk(1, 0, 3'd6, 8'h00, 0, 0, 3'd0, 8'h00, 1, 0, 8'h78, 8'h00);

    // Reset with both requesters valid.
    i_rst = 1'b1; v0 = 1'b1; v1 = 1'b1;
    for (int k = 0; k < 2; k++) begin
      @(posedge clk); #1;
      check("rst_ready0", r0, 0);
      check("rst_ready1", r1, 0);
      check("rst_mem_en", mem_en, 0);
      check("rst_mem_we", mem_we, 0);
      check("rst_mem_addr", mem_addr, 0);
      check("rst_rsp_dout0", rd0, 0);
      check("rst_rsp_valid", {rv1, rv0}, 0);
    end
    @(negedge clk);
    i_rst = 1'b0;
    idle();
    #1;
    obs_q.delete();
    repeat (10) @(posedge clk);
    #1;
    check("rst_no_mem_en", mem_en, 0);
    compare_rsp("rst_rsp");

    // Write addr 0 = 12, then read addr 0 from requester 0.
    do_reset();
    @(negedge clk);
    v0 = 1'b1; we0 = 1'b1; a0 = 3'd0; d0 = 8'd12;
    #1 check("wr_ready", r0, 1);
    @(posedge clk); #1;
    e0 = cyc;
    check("wr_mem_en", mem_en, 1);
    check("wr_mem_we", mem_we, 1);
    check("wr_mem_din", mem_din, 12);
    @(negedge clk);
    we0 = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      #1 check($sformatf("raw_ready_e%0d", k), r0, (k == 6) ? 1 : 0);
      @(posedge clk);
      @(negedge clk);
    end
    idle();
    exp_q.push_back('{e0 + 13, 1'b0, 8'd12});
    repeat (14) @(posedge clk);
    #1 compare_rsp("raw_rsp");

    // Table: arbitration, hazard bypass, read-vs-write same address.
    do_reset();
    for (int i = 0; i < 21; i++) begin
      @(negedge clk);
      v0 = vt[i].v0; we0 = vt[i].we0; a0 = vt[i].a0; d0 = vt[i].d0;
      v1 = vt[i].v1; we1 = vt[i].we1; a1 = vt[i].a1; d1 = vt[i].d1;
      #1;
      check($sformatf("vec%0d_ready0", i), r0, vt[i].r0);
      check($sformatf("vec%0d_ready1", i), r1, vt[i].r1);
      @(posedge clk); #1;
      check($sformatf("vec%0d_mem_en", i), mem_en, vt[i].r0 | vt[i].r1);
      if (vt[i].r0) begin
        check($sformatf("vec%0d_mem_addr", i), mem_addr, vt[i].a0);
        check($sformatf("vec%0d_mem_we", i), mem_we, vt[i].we0);
        if (!vt[i].we0) exp_q.push_back('{cyc + 7, 1'b0, vt[i].x0});
      end else if (vt[i].r1) begin
        check($sformatf("vec%0d_mem_addr", i), mem_addr, vt[i].a1);
        check($sformatf("vec%0d_mem_we", i), mem_we, vt[i].we1);
        if (!vt[i].we1) exp_q.push_back('{cyc + 7, 1'b1, vt[i].x1});
      end
    end
    @(negedge clk);
    idle();
    repeat (12) @(posedge clk);
    #1 compare_rsp("vec_rsp");

    // Reset two cycles after a read is accepted: no response may appear.
    do_reset();
    @(negedge clk);
    v0 = 1'b1; we0 = 1'b0; a0 = 3'd1;
    #1 check("mid_ready", r0, 1);
    @(posedge clk);
    @(negedge clk);
    idle();
    @(posedge clk);
    @(negedge clk);
    i_rst = 1'b1; v0 = 1'b1; v1 = 1'b1;
    #1;
    check("mid_rst_ready0", r0, 0);
    check("mid_rst_ready1", r1, 0);
    repeat (2) @(posedge clk);
    #1 check("mid_rst_mem_en", mem_en, 0);
    @(negedge clk);
    i_rst = 1'b0;
    idle();
    repeat (12) @(posedge clk);
    #1 compare_rsp("mid_rsp");

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
